// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller and its skid FIFO.
package fetch_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Force a byte address onto a 4-byte instruction boundary.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry FIFO of {pc, instruction} pairs; clear beats push and pop.
module fetch_skid_fifo
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  fetch_entry_t i_push_data,
    input  logic         i_pop,
    input  logic         i_clear,
    output logic [1:0]   o_count,
    output fetch_entry_t o_head
);

    fetch_entry_t r_mem [0:1];
    logic         r_rd_ptr;
    logic         r_wr_ptr;
    logic [1:0]   r_count;

    logic w_do_pop;
    logic w_do_push;

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign w_do_pop  = i_pop && (r_count != 2'd0);
    assign w_do_push = i_push && ((r_count != 2'd2) || w_do_pop);

    // Storage array; contents are don't-care while the count says empty.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_clear && !reset) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/instruction_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues reads to a 1-cycle synchronous ROM and feeds
// decode through a 2-entry skid FIFO, with epoch-based squashing on redirects.
module instruction_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 2
)
(
    input  logic                clk,
    input  logic                reset,
    input  logic                fetch_enable,
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_pc,
    output logic                imem_read_enable,
    output logic [XLEN-1:0]     imem_address,
    input  logic [INSTR_W-1:0]  imem_instruction,
    output logic                if_valid,
    input  logic                if_ready,
    output logic [XLEN-1:0]     if_pc,
    output logic [INSTR_W-1:0]  if_instruction
);

    if (FIFO_DEPTH != 2) begin : g_depth_check
        $fatal(1, "instruction_fetch_ctrl: FIFO_DEPTH must be 2");
    end

    fetch_state_t    r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_inflight;
    logic            r_epoch;
    logic [XLEN-1:0] r_resp_pc;
    logic            r_resp_epoch;

    logic            w_credit_ok;
    logic            w_issue;
    logic            w_resp_valid;
    logic            w_fifo_empty;
    logic            w_handshake;
    logic            w_push;
    logic            w_pop;
    logic [1:0]      w_count;
    fetch_entry_t    w_head;
    fetch_entry_t    w_resp_entry;
    fetch_entry_t    w_out;

    // The outstanding read already owns a slot, so FIFO space is reserved before issue.
    assign w_credit_ok  = ({1'b0, w_count} + {2'b00, r_inflight}) < 3'd2;
    assign w_issue      = (r_state == RUN) && fetch_enable && !redirect_valid
                          && !reset && w_credit_ok;
    assign w_resp_valid = r_inflight && (r_resp_epoch == r_epoch);
    assign w_fifo_empty = (w_count == 2'd0);

    assign w_resp_entry.pc    = r_resp_pc;
    assign w_resp_entry.instr = imem_instruction;

    // An arriving response is shown directly when nothing older is queued.
    assign if_valid    = !w_fifo_empty || w_resp_valid;
    assign w_handshake = if_valid && if_ready;
    assign w_pop       = w_handshake && !w_fifo_empty;
    assign w_push      = w_resp_valid && !(w_fifo_empty && w_handshake);

    // Decode-side view: queued head first, otherwise the response on the ROM bus.
    always_comb begin
        w_out = '0;
        if (!w_fifo_empty) begin
            w_out = w_head;
        end else if (w_resp_valid) begin
            w_out = w_resp_entry;
        end else begin
            w_out = '0;
        end
    end

    assign if_pc            = w_out.pc;
    assign if_instruction   = w_out.instr;
    assign imem_read_enable = w_issue;
    assign imem_address     = r_pc;

    // Fetch FSM with PC, in-flight tracking and redirect epoch.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_pc         <= RESET_PC;
            r_inflight   <= 1'b0;
            r_epoch      <= 1'b0;
            r_resp_pc    <= '0;
            r_resp_epoch <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_resp_pc    <= r_pc;
                r_resp_epoch <= r_epoch;
            end
            if (redirect_valid) begin
                r_pc    <= align_word(redirect_pc);
                r_epoch <= ~r_epoch;
                r_state <= FLUSH;
            end else begin
                if (w_issue) begin
                    r_pc <= r_pc + 32'd4;
                end
                case (r_state)
                    IDLE:    r_state <= fetch_enable ? RUN : IDLE;
                    RUN:     r_state <= fetch_enable ? RUN : IDLE;
                    FLUSH:   r_state <= fetch_enable ? RUN : IDLE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    fetch_skid_fifo u_skid (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data (w_resp_entry),
        .i_pop       (w_pop),
        .i_clear     (redirect_valid),
        .o_count     (w_count),
        .o_head      (w_head)
    );

endmodule
